// File: rtl/d_flip_flop_bank.sv
// -----------------------------------------------------------------------------
// d_flip_flop_bank
//
// Purpose:
//   Parameterised bank of positive-edge D flip-flops for the 8-bit computer
//   datapath. Each bit provides a true output (Q) and a complement output
//   (not_Q). It holds a value stable between clock edges, for example flags
//   and pipeline latches.
//
// Parameters:
//   WIDTH        number of flip-flops in the bank (legal range 1..64)
//   RESET_VALUE  value loaded into Q while reset is asserted
//
// Ports:
//   clk      in   1      system clock; state changes on its rising edge
//   reset    in   1      asynchronous, active-high reset
//   enable   in   1      load enable; the bank holds its value when 0
//   clear    in   1      synchronous clear to all-zeros (overrides enable)
//   data     in   WIDTH  D input
//   Q        out  WIDTH  registered output
//   not_Q    out  WIDTH  bitwise complement of Q
//   changed  out  1      only when D_FLIP_FLOP_BANK_CHANGED_EN is defined;
//                        registered pulse, high for one cycle after an edge
//                        at which Q took a new value
//
// Optional feature macro: D_FLIP_FLOP_BANK_CHANGED_EN
//
// Reset release:
//   r_armed clears asynchronously with reset. It sets again on the first
//   falling clock edge with reset low. A rising edge that coincides with the
//   release of reset therefore does not capture. The following rising edge
//   does capture, because a falling edge always sits between the two.
// -----------------------------------------------------------------------------
module d_flip_flop_bank #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] not_Q
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
    ,
    output logic             changed
`endif
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             r_armed;

    // Capture is qualified by r_armed so that a release coincident with a
    // rising edge never loads data on that edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Priority: clear over enable over hold.
    always_comb begin
        w_q_next = r_q;
        if (clear) begin
            w_q_next = '0;
        end else if (enable) begin
            w_q_next = data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (r_armed) begin
            r_q <= w_q_next;
        end
    end

    assign Q     = r_q;
    assign not_Q = ~r_q;

`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
    logic r_changed;

    // The pulse is computed from the same next-state value the bank loads.
    // An edge that is not armed loads nothing, so it reports no change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else if (r_armed) begin
            r_changed <= (w_q_next != r_q);
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign changed = r_changed;
`endif

endmodule

// File: tb/tb_d_flip_flop_bank.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop_bank
//
// The bench drives two instances from one clock and one reset:
//   u_dut8  WIDTH=8, RESET_VALUE=8'hA5  (reset, release timing, enable/clear,
//           changed flag)
//   u_dut1  WIDTH=1, RESET_VALUE=1'b0   (capture, glitch rejection)
//
// Driver code pushes hand-computed expectations into exp_q and then raises
// sample_ev. The monitor drains the queue and compares each entry with the
// outputs of the selected instance.
// -----------------------------------------------------------------------------
module tb_d_flip_flop_bank;

    localparam int W = 16;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset;

    always #5 clk = ~clk;

    // stimulus and observed signals
    logic       en8;
    logic       clr8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] nq8;
    logic       en1;
    logic       clr1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] nq1;
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
    logic       chg8;
    logic       chg1;
`endif

    d_flip_flop_bank #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk     (clk),
        .reset   (reset),
        .enable  (en8),
        .clear   (clr8),
        .data    (d8),
        .Q       (q8),
        .not_Q   (nq8)
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        ,
        .changed (chg8)
`endif
    );

    d_flip_flop_bank #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .enable  (en1),
        .clear   (clr1),
        .data    (d1),
        .Q       (q1),
        .not_Q   (nq1)
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        ,
        .changed (chg1)
`endif
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    event         sample_ev;

    task automatic expect8(input string n, input logic [7:0] q, input logic [7:0] nq);
        exp_q.push_back({q, nq});
        sel_q.push_back(0);
        name_q.push_back(n);
    endtask

    task automatic expect1(input string n, input logic q, input logic nq);
        exp_q.push_back({7'b0, q, 7'b0, nq});
        sel_q.push_back(1);
        name_q.push_back(n);
    endtask

    task automatic expect_chg(input string n, input logic c);
        exp_q.push_back({15'b0, c});
        sel_q.push_back(2);
        name_q.push_back(n);
    endtask

    task automatic do_sample();
        -> sample_ev;
        #1;
    endtask

    // monitor
    initial begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        int           sel;
        string        nm;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                sel = sel_q.pop_front();
                nm  = name_q.pop_front();
                act = '0;
                case (sel)
                    0: act = {q8, nq8};
                    1: act = {7'b0, q1, 7'b0, nq1};
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
                    2: act = {15'b0, chg8};
`endif
                    default: act = '1;
                endcase
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
                end
            end
        end
    end

    // driver
    initial begin
        reset = 1'b1;
        en8   = 1'b0;
        clr8  = 1'b0;
        d8    = 8'h00;
        en1   = 1'b0;
        clr1  = 1'b0;
        d1    = 1'b0;

        // reset state
        #2;
        expect8("rst_val8", 8'hA5, 8'h5A);
        expect1("rst_val1", 1'b0, 1'b1);
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        expect_chg("rst_chg", 1'b0);
`endif
        do_sample();

        // edges during reset are ignored
        en8 = 1'b1;
        d8  = 8'hFF;
        en1 = 1'b1;
        d1  = 1'b1;
        @(posedge clk); #2;
        expect8("rst_edge8", 8'hA5, 8'h5A);
        expect1("rst_edge1", 1'b0, 1'b1);
        do_sample();

        // release exactly at a rising edge: that edge does not capture
        d8 = 8'h0F;
        d1 = 1'b0;
        @(posedge clk);
        reset = 1'b0;
        #2;
        expect8("rel_coincident8", 8'hA5, 8'h5A);
        expect1("rel_coincident1", 1'b0, 1'b1);
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        expect_chg("rel_coincident_chg", 1'b0);
`endif
        do_sample();

        @(posedge clk); #2;
        expect8("first_capture8", 8'h0F, 8'hF0);
        expect1("cap_d0", 1'b0, 1'b1);
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        expect_chg("first_capture_chg", 1'b1);
`endif
        do_sample();

        d1 = 1'b1;
        @(posedge clk); #2;
        expect1("cap_d1", 1'b1, 1'b0);
        do_sample();

        // same-time-step glitch between edges
        @(negedge clk);
        d1 = 1'b0;
        d1 = 1'b1;
        #1;
        expect1("glitch_hold", 1'b1, 1'b0);
        do_sample();
        @(posedge clk); #2;
        expect1("glitch_edge", 1'b1, 1'b0);
        do_sample();

        // data low only across a falling edge
        d1 = 1'b0;
        @(negedge clk); #2;
        expect1("falling_only", 1'b1, 1'b0);
        do_sample();
        d1 = 1'b1;
        @(posedge clk); #2;
        expect1("after_falling", 1'b1, 1'b0);
        do_sample();

        // 1-bit hold and clear
        en1 = 1'b0;
        d1  = 1'b0;
        @(posedge clk); #2;
        expect1("hold1", 1'b1, 1'b0);
        do_sample();
        clr1 = 1'b1;
        @(posedge clk); #2;
        expect1("clear1", 1'b0, 1'b1);
        do_sample();
        clr1 = 1'b0;

        // 8-bit enable / clear
        en8 = 1'b1;
        d8  = 8'h3C;
        @(posedge clk); #2;
        expect8("load_3c", 8'h3C, 8'hC3);
        do_sample();
        en8 = 1'b0;
        d8  = 8'hFF;
        repeat (3) @(posedge clk);
        #2;
        expect8("hold_3edges", 8'h3C, 8'hC3);
        do_sample();
        clr8 = 1'b1;
        en8  = 1'b1;
        @(posedge clk); #2;
        expect8("clear_over_en", 8'h00, 8'hFF);
        do_sample();
        clr8 = 1'b0;
        d8   = 8'h81;
        @(posedge clk); #2;
        expect8("load_81", 8'h81, 8'h7E);
        do_sample();
        clr8 = 1'b1;
        en8  = 1'b0;
        @(posedge clk); #2;
        expect8("clear_no_en", 8'h00, 8'hFF);
        do_sample();
        clr8 = 1'b0;
        en8  = 1'b1;

        // reset asserted mid-cycle takes effect before the next edge
        d8 = 8'h66;
        @(posedge clk); #2;
        expect8("load_66", 8'h66, 8'h99);
        do_sample();
        reset = 1'b1;
        #1;
        expect8("async_rst", 8'hA5, 8'h5A);
`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        expect_chg("async_rst_chg", 1'b0);
`endif
        do_sample();
        d8 = 8'hFF;
        @(posedge clk); #2;
        expect8("rst_hold_edge", 8'hA5, 8'h5A);
        do_sample();
        reset = 1'b0;
        @(posedge clk); #2;
        expect8("rel_midcycle", 8'hFF, 8'h00);
        do_sample();

`ifdef D_FLIP_FLOP_BANK_CHANGED_EN
        // changed flag
        d8 = 8'h00;
        @(posedge clk); #2;
        expect8("chg_load_00", 8'h00, 8'hFF);
        do_sample();
        d8 = 8'h01;
        @(posedge clk); #2;
        expect8("chg_load_01", 8'h01, 8'hFE);
        expect_chg("chg_pulse", 1'b1);
        do_sample();
        @(posedge clk); #2;
        expect_chg("chg_same", 1'b0);
        do_sample();
`endif

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_flip_flop_bank.md
Name: d_flip_flop_bank

Overview:
- Parameterised bank of positive-edge D flip-flops for the 8-bit computer datapath.
- Each bit provides true (Q) and complement (not_Q) outputs.
- Used wherever a value must be held stable between clock edges, e.g. flags and pipeline latches.
- The input is sampled only on the rising clock edge. Input activity between edges, including multiple changes in the same time step, never affects the outputs.

Parameters:
- WIDTH, 1, number of flip-flops (bits) in the bank; legal range 1..64.
- RESET_VALUE, 0 (WIDTH bits), value loaded into Q while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes except reset occur on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  load enable; when 0 the bank holds its value.
- clear  input  1  synchronous clear to all-zeros.
- data  input  WIDTH  D input.
- Q  output  WIDTH  registered output.
- not_Q  output  WIDTH  bitwise complement of Q.

Behaviour:
- Reset is asynchronous and active-high. When reset goes to 1, Q immediately becomes RESET_VALUE and not_Q becomes ~RESET_VALUE, without waiting for a clock edge.
- While reset is 1, clock edges are ignored.
- Reset release: the first capture occurs at the first rising edge strictly after reset is 0. An edge coincident with deassertion does not capture.
- Rising edge of clk, reset=0, priority order:
  - clear=1: Q <= 0.
  - else enable=1: Q <= data.
  - else: Q holds.
- Latency: data is visible on Q in the same delta step as the capturing rising edge; there are no extra pipeline stages.
- Falling edges of clk have no effect.
- Data changing any number of times between edges, or within the same time step as a non-edge, is ignored. Only the value settled before the rising edge is captured.
- not_Q is always exactly ~Q, combinationally derived from the stored value, including during reset and at time zero after reset.
- There is no combinational path from data, enable or clear to Q or not_Q.
- Before the first reset or capture, Q is undefined. Integration must assert reset at power-up.
- Each bit is independent; there are no cross-bit interactions.

Optional Feature:
- Macro: D_FLIP_FLOP_BANK_CHANGED_EN.
- With the macro defined:
  - Adds output port changed (1 bit, registered).
  - changed is 1 for exactly one clk cycle following any rising edge at which Q took a value different from its previous value.
  - changed is 0 during reset and on the first edge after reset release unless Q changed on that edge.
- Without the macro: the changed port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, assert reset mid-cycle -> Q=8'hA5 and not_Q=8'h5A immediately, before the next edge; clock edges during reset leave Q unchanged.
- Capture: WIDTH=1, reset released, enable=1, data=0 then rising edge -> Q=0, not_Q=1. Then data=1 and rising edge -> Q=1, not_Q=0.
- Mid-cycle glitch: after Q=1, set data 0 then 1 in the same time step between edges -> Q stays 1 until the next edge, then captures 1. Data=0 held across a falling edge only -> no change.
- Enable/clear: Q=8'h3C; enable=0, data=8'hFF, 3 edges -> Q stays 8'h3C. Then clear=1 and enable=1 together -> Q=8'h00, not_Q=8'hFF.
- Reset release timing: deassert reset exactly at a rising edge with data=8'h0F -> Q stays RESET_VALUE. Next edge -> Q=8'h0F.
- Changed flag (macro defined): Q 8'h00 -> 8'h01 -> changed=1 for one cycle. Next edge with same data -> changed=0.
